// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed access latency
module dmem_responder #(
    parameter int N         = 64,
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_M,
    input  logic         we_M,
    input  logic [N-1:0] address_M,
    input  logic [N-1:0] writeData_M,
    output logic [N-1:0] readData_M,
    output logic         ack_M,
    output logic         busy_M,
    output logic         misaligned_M
);

    localparam int WORDS = 1 << ADDR_BITS;
    localparam int AW    = ADDR_BITS + 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q;
    logic [AW-1:0]  addr_q;
    logic [N-1:0]   wdata_q;
    logic [N-1:0]   rdata_q, rdata_d;
    logic           mis_q, mis_d;
    logic [N-1:0]   mem [WORDS];

    logic                 accept;
    logic                 access;
    logic                 aligned;
    logic [ADDR_BITS-1:0] idx;
    logic                 unused_addr_hi;

    assign accept         = (state_q == S_IDLE) && req_M;
    assign access         = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign aligned        = (addr_q[2:0] == 3'b000);
    assign idx            = addr_q[AW-1:3];
    assign unused_addr_hi = ^address_M[N-1:AW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_M) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_M       = (state_q != S_IDLE);
        ack_M        = (state_q == S_ACK);
        misaligned_M = mis_q && (state_q == S_ACK);
        readData_M   = rdata_q;
    end

    // Request fields are frozen at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we_M;
            addr_q  <= address_M[AW-1:0];
            wdata_q <= writeData_M;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        mis_d   = mis_q;
        if (access) begin
            mis_d = !aligned;
            if (!aligned) begin
                rdata_d = '0;
            end else if (!we_q) begin
                rdata_d = mem[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // No reset on the array: contents survive reset, and an aborted store never reaches access.
    always_ff @(posedge clk) begin
        if (access && we_q && aligned) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule
